ps2_xmt: RTL

PS/2 host-to-device transmitter. It is the send direction complementing the keyboard/mouse receiver and is used for mouse/keyboard commands such as 0xF4 (enable reporting) and 0xFF (reset).
- Bus slave on the system bus (50 MHz `clk`), occupying 2 words in the extended I/O window.
- Drives the open-drain PS/2 clock and data lines through separate pull-low enables.

---
 rtl/ps2_xmt.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_xmt.sv
// PS/2 host-to-device transmitter: bus-programmable command byte, clock inhibit,
// request-to-send, bit shifting on device clock falling edges and ack sampling.
module ps2_xmt #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_drv,
  output logic        ps2_data_drv
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ien, w_ien_nxt;
  logic             r_clk_drv, w_clk_drv_nxt;
  logic             r_data_drv, w_data_drv_nxt;
  logic             r_irq;
  logic [1:0]       r_clk_sync, r_data_sync;
  logic             r_clk_prev;
  logic             w_fall, w_busy, w_wr0, w_wr1;
  logic [15:0]      w_frame;
  logic [23:0]      w_unused_bits;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  assign ack           = stb;
  assign irq           = r_irq;
  assign ps2_clk_drv   = r_clk_drv;
  assign ps2_data_drv  = r_data_drv;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_fall        = r_clk_prev & ~r_clk_sync[1];
  assign w_wr0         = stb & we & ~addr;
  assign w_wr1         = stb & we & addr;
  assign w_frame       = {6'd0, 1'b1, odd_parity(r_byte), r_byte};
  assign w_unused_bits = data_in[31:8];

  // Bus read mux, zero wait state.
  always_comb begin
    data_out = 32'd0;
    if (stb && !we) begin
      if (addr) begin
        data_out = {28'd0, r_ien, r_err, r_done, w_busy};
      end else begin
        data_out = {24'd0, r_byte};
      end
    end else begin
      data_out = 32'd0;
    end
  end

  // Next-state logic; the FSM section follows the bus section so status sets win over clears.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_ien_nxt      = r_ien;
    w_clk_drv_nxt  = 1'b0;
    w_data_drv_nxt = r_data_drv;

    if (w_wr1) begin
      w_ien_nxt = data_in[3];
      if (data_in[1]) begin
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
      end else begin
        w_done_nxt = r_done;
      end
    end else begin
      w_ien_nxt = r_ien;
    end

    case (r_state)
      ST_IDLE: begin
        w_data_drv_nxt = 1'b0;
        if (w_wr0) begin
          w_byte_nxt    = data_in[7:0];
          w_done_nxt    = 1'b0;
          w_err_nxt     = 1'b0;
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_clk_drv_nxt = 1'b1;
          w_state_nxt   = ST_INHIBIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt_nxt      = {CNT_W{1'b0}};
          w_bit_nxt      = 4'd0;
          w_data_drv_nxt = 1'b1;
          w_state_nxt    = ST_REQ;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
          w_clk_drv_nxt = 1'b1;
        end
      end
      ST_REQ, ST_SHIFT, ST_ACK: begin
        if (r_cnt == TO_LAST) begin
          w_err_nxt      = 1'b1;
          w_data_drv_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_fall) begin
            w_bit_nxt = r_bit + 4'd1;
            if (r_state == ST_ACK) begin
              // Edge 11: device pulls data low to acknowledge.
              if (r_data_sync[1]) begin
                w_err_nxt = 1'b1;
              end else begin
                w_done_nxt = 1'b1;
              end
              w_data_drv_nxt = 1'b0;
              w_state_nxt    = ST_RECOVER;
            end else begin
              w_data_drv_nxt = ~w_frame[r_bit];
              w_state_nxt    = (r_bit == 4'd9) ? ST_ACK : ST_SHIFT;
            end
          end else begin
            w_bit_nxt = r_bit;
          end
        end
      end
      ST_RECOVER: begin
        w_data_drv_nxt = 1'b0;
        if (r_clk_sync[1] && r_data_sync[1]) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RECOVER;
        end
      end
      default: begin
        w_data_drv_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State, status, line drivers and input synchronisers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_bit       <= 4'd0;
      r_byte      <= 8'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ien       <= 1'b0;
      r_clk_drv   <= 1'b0;
      r_data_drv  <= 1'b0;
      r_irq       <= 1'b0;
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_byte      <= w_byte_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_ien       <= w_ien_nxt;
      r_clk_drv   <= w_clk_drv_nxt;
      r_data_drv  <= w_data_drv_nxt;
      r_irq       <= w_ien_nxt & (w_done_nxt | w_err_nxt);
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

endmodule
